// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module : calc_pkg
// Brief  : Shared types and constants for the calculator operand-entry path.
// Rev    : 1.0  initial release
// ============================================================================
package calc_pkg;

   localparam int         NDIG_DEFAULT = 4;
   localparam logic [3:0] BCD_MAX      = 4'd9;

   typedef enum logic [1:0] {
      ENT_A = 2'd0,
      ENT_B = 2'd1,
      HOLD  = 2'd2
   } state_e;

   // Digit counters must be able to hold the value NDIG itself (register full).
   function automatic int cnt_width(input int ndig);
      return $clog2(ndig + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/digit_demux_if.sv
`default_nettype none
// ============================================================================
// Module : digit_demux_if
// Brief  : Keypad digit / operator input and operand output bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface digit_demux_if
   import calc_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT
);
   logic              digit_valid;
   logic [3:0]        digit;
   logic              digit_ready;
   logic              op_key;
   logic              clr;
   logic [4*NDIG-1:0] opnd_a;
   logic [4*NDIG-1:0] opnd_b;
   logic              opnd_valid;
   logic              opnd_ack;
   logic              sel;
   logic              err;

   modport master (
      output digit_valid, digit, op_key, clr, opnd_ack,
      input  digit_ready, opnd_a, opnd_b, opnd_valid, sel, err
   );

   modport slave (
      input  digit_valid, digit, op_key, clr, opnd_ack,
      output digit_ready, opnd_a, opnd_b, opnd_valid, sel, err
   );
endinterface
`default_nettype wire

// File: rtl/bcd_shift_reg.sv
`default_nettype none
// ============================================================================
// Module : bcd_shift_reg
// Brief  : NDIG-digit left-shifting operand register with digit count.
// Rev    : 1.0  initial release
// ============================================================================
module bcd_shift_reg
   import calc_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT
) (
   input  wire logic                         clk,
   input  wire logic                         rst_n,
   input  wire logic                         load,
   input  wire logic                         clr,
   input  wire logic [3:0]                   din,
   output logic      [4*NDIG-1:0]            dout,
   output logic      [cnt_width(NDIG)-1:0]   cnt
);
   localparam int CNT_W = cnt_width(NDIG);

   logic [4*NDIG-1:0] data_q, data_d, shifted;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   generate
      if (NDIG == 1) begin : g_single
         assign shifted = din;
      end else begin : g_multi
         assign shifted = {data_q[4*NDIG-5:0], din};
      end
   endgenerate

   // Clear wins over load; the parent only loads while there is room.
   always_comb begin
      data_d = data_q;
      cnt_d  = cnt_q;
      if (clr) begin
         data_d = '0;
         cnt_d  = '0;
      end else if (load) begin
         data_d = shifted;
         cnt_d  = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
         cnt_q  <= '0;
      end else begin
         data_q <= data_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout = data_q;
   assign cnt  = cnt_q;

endmodule
`default_nettype wire

// File: rtl/digit_demux.sv
`default_nettype none
// ============================================================================
// Module : digit_demux
// Brief  : Routes keypad digits into operands A then B, holds them for a consumer.
//          Define DIGIT_DEMUX_BCD_CHECK_EN to reject digits above 9 with an err pulse.
// Rev    : 1.0  initial release
// ============================================================================
module digit_demux
   import calc_pkg::*;
#(
   parameter int NDIG = NDIG_DEFAULT
) (
   input wire logic     clk,
   input wire logic     rst_n,
   digit_demux_if.slave bus
);
   localparam int               CNT_W  = cnt_width(NDIG);
   localparam logic [CNT_W-1:0] C_NDIG = CNT_W'(NDIG);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_a, cnt_b;
   logic             ready, accept, digit_ok;
   logic             load_a, load_b, clr_regs;

   assign ready  = (state_q == ENT_A && cnt_a < C_NDIG) ||
                   (state_q == ENT_B && cnt_b < C_NDIG);
   assign accept = bus.digit_valid && ready;

`ifdef DIGIT_DEMUX_BCD_CHECK_EN
   logic err_q, err_d;

   assign digit_ok = (bus.digit <= BCD_MAX);
   assign err_d    = accept && !digit_ok && !bus.clr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= err_d;
   end

   assign bus.err = err_q;
`else
   assign digit_ok = 1'b1;
   assign bus.err  = 1'b0;
`endif

   assign load_a   = accept && digit_ok && (state_q == ENT_A);
   assign load_b   = accept && digit_ok && (state_q == ENT_B);
   assign clr_regs = bus.clr || (state_q == HOLD && bus.opnd_ack);

   always_comb begin
      state_d = state_q;
      if (bus.clr) begin
         state_d = ENT_A;
      end else begin
         case (state_q)
            ENT_A:   if (bus.op_key)   state_d = ENT_B;
            ENT_B:   if (bus.op_key)   state_d = HOLD;
            HOLD:    if (bus.opnd_ack) state_d = ENT_A;
            default:                   state_d = ENT_A;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ENT_A;
      else        state_q <= state_d;
   end

   bcd_shift_reg #(.NDIG(NDIG)) u_reg_a (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_a),
      .clr   (clr_regs),
      .din   (bus.digit),
      .dout  (bus.opnd_a),
      .cnt   (cnt_a)
   );

   bcd_shift_reg #(.NDIG(NDIG)) u_reg_b (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load_b),
      .clr   (clr_regs),
      .din   (bus.digit),
      .dout  (bus.opnd_b),
      .cnt   (cnt_b)
   );

   // Operands are complete exactly while held for the consumer.
   assign bus.digit_ready = ready;
   assign bus.sel         = (state_q == ENT_A);
   assign bus.opnd_valid  = (state_q == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_digit_demux.sv
`default_nettype none
// ============================================================================
// Module : tb_digit_demux
// Brief  : Directed and random stimulus against a digit-list model of digit_demux.
// Rev    : 1.0  initial release
// ============================================================================
module tb_digit_demux;
   localparam int NDIG = 4;

   logic clk = 1'b0;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;

   // Model: entry phase (0 = A, 1 = B, 2 = held) and digits in arrival order.
   int          ph;
   int unsigned qa[$];
   int unsigned qb[$];
   bit          err_m;

   digit_demux_if #(.NDIG(NDIG)) bus ();

   digit_demux #(.NDIG(NDIG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] pack(input int unsigned q[$]);
      logic [63:0] v = '0;
      foreach (q[i]) v = (v << 4) | 64'(q[i]);
      return v;
   endfunction

   function automatic bit is_bad(input int unsigned d);
`ifdef DIGIT_DEMUX_BCD_CHECK_EN
      return d > 9;
`else
      return 1'b0;
`endif
   endfunction

   function automatic void model_reset();
      ph = 0;
      qa.delete();
      qb.delete();
      err_m = 1'b0;
   endfunction

   function automatic void model_step(input bit v, input int unsigned d, input bit op,
                                      input bit c, input bit ack);
      err_m = 1'b0;
      if (c) begin
         model_reset();
      end else if (ph == 0) begin
         if (v && qa.size() < NDIG) begin
            if (is_bad(d)) err_m = 1'b1;
            else           qa.push_back(d);
         end
         if (op) ph = 1;
      end else if (ph == 1) begin
         if (v && qb.size() < NDIG) begin
            if (is_bad(d)) err_m = 1'b1;
            else           qb.push_back(d);
         end
         if (op) ph = 2;
      end else if (ack) begin
         model_reset();
      end
   endfunction

   task automatic check_all(input string tag);
      bit rdy;
      rdy = (ph == 0) ? (qa.size() < NDIG) : (ph == 1) ? (qb.size() < NDIG) : 1'b0;
      chk({tag, ".sel"},   64'(bus.sel),         64'(ph == 0));
      chk({tag, ".ready"}, 64'(bus.digit_ready), 64'(rdy));
      chk({tag, ".valid"}, 64'(bus.opnd_valid),  64'(ph == 2));
      chk({tag, ".a"},     64'(bus.opnd_a),      pack(qa));
      chk({tag, ".b"},     64'(bus.opnd_b),      pack(qb));
      chk({tag, ".err"},   64'(bus.err),         64'(err_m));
   endtask

   task automatic step(input bit v, input int unsigned d, input bit op, input bit c,
                       input bit ack, input string tag);
      @(negedge clk);
      bus.digit_valid = v;
      bus.digit       = d[3:0];
      bus.op_key      = op;
      bus.clr         = c;
      bus.opnd_ack    = ack;
      @(posedge clk);
      model_step(v, d & 32'hF, op, c, ack);
      #1 check_all(tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 0, 1'b0, 1'b0, 1'b0, tag);
   endtask

   initial begin
      rst_n           = 1'b0;
      bus.digit_valid = 1'b0;
      bus.digit       = 4'd0;
      bus.op_key      = 1'b0;
      bus.clr         = 1'b0;
      bus.opnd_ack    = 1'b0;
      model_reset();
      #2;
      chk("rst.sel",   64'(bus.sel),         64'd1);
      chk("rst.ready", 64'(bus.digit_ready), 64'd1);
      chk("rst.valid", 64'(bus.opnd_valid),  64'd0);
      chk("rst.a",     64'(bus.opnd_a),      64'd0);
      chk("rst.err",   64'(bus.err),         64'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // Two operands entered and handed over.
      step(1, 1, 0, 0, 0, "e1");
      step(1, 2, 0, 0, 0, "e2");
      step(1, 3, 0, 0, 0, "e3");
      step(0, 0, 1, 0, 0, "opA");
      step(1, 4, 0, 0, 0, "e4");
      step(1, 5, 0, 0, 0, "e5");
      step(0, 0, 1, 0, 0, "opB");
      chk("pair.a",     64'(bus.opnd_a),     64'h0123);
      chk("pair.b",     64'(bus.opnd_b),     64'h0045);
      chk("pair.valid", 64'(bus.opnd_valid), 64'd1);
      step(0, 0, 0, 0, 1, "ack1");

      // Overfilling operand A.
      for (int i = 1; i <= 5; i++) begin
         step(1, i, 0, 0, 0, $sformatf("fill%0d", i));
         if (i == 4) chk("full.ready", 64'(bus.digit_ready), 64'd0);
      end
      chk("full.a", 64'(bus.opnd_a), 64'h1234);

      // Digit and operator key in the same cycle.
      step(0, 0, 0, 1, 0, "clr1");
      step(1, 7, 1, 0, 0, "d7op");
      chk("d7op.a",   64'(bus.opnd_a[3:0]), 64'd7);
      chk("d7op.sel", 64'(bus.sel),         64'd0);

      // Held operands ignore digits and keys until acknowledged.
      step(0, 0, 1, 0, 0, "toHold");
      step(1, 3, 1, 0, 0, "holdIgn");
      chk("holdIgn.a", 64'(bus.opnd_a), 64'h0007);
      step(0, 0, 0, 0, 1, "ack2");
      chk("ack2.valid", 64'(bus.opnd_valid), 64'd0);
      chk("ack2.a",     64'(bus.opnd_a),     64'd0);

      // Non-BCD nibble.
      step(1, 2, 0, 0, 0, "pre");
      step(1, 4'hA, 0, 0, 0, "nibA");
`ifdef DIGIT_DEMUX_BCD_CHECK_EN
      chk("nibA.err", 64'(bus.err),    64'd1);
      chk("nibA.a",   64'(bus.opnd_a), 64'h0002);
      idle("nibA.after");
      chk("nibA.err0", 64'(bus.err), 64'd0);
`else
      chk("nibA.a", 64'(bus.opnd_a[3:0]), 64'hA);
      chk("nibA.err", 64'(bus.err), 64'd0);
`endif

      // Asynchronous reset mid-entry.
      step(0, 0, 0, 1, 0, "clr2");
      step(1, 8, 0, 0, 0, "e8");
      step(1, 9, 0, 0, 0, "e9");
      @(negedge clk);
      bus.digit_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("arst.a",     64'(bus.opnd_a),      64'd0);
      chk("arst.sel",   64'(bus.sel),         64'd1);
      chk("arst.ready", 64'(bus.digit_ready), 64'd1);
      chk("arst.valid", 64'(bus.opnd_valid),  64'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Clear from the held state.
      step(1, 6, 1, 0, 0, "h1");
      step(0, 0, 1, 0, 0, "h2");
      step(0, 0, 0, 1, 0, "clrHold");
      chk("clrHold.sel", 64'(bus.sel), 64'd1);

      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(99) < 60, $urandom_range(15), $urandom_range(99) < 12,
              $urandom_range(99) < 2, $urandom_range(99) < 25, $sformatf("rnd%0d", n));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/digit_demux.md
DIGIT_DEMUX -- requirements
Module: digit_demux

Interface
REQ-001 SHALL have parameter: NDIG, 4, BCD digits per operand register (1..8).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: digit_valid  input  1  keypad digit strobe.
REQ-005 SHALL have port: digit  input  4  BCD digit value.
REQ-006 SHALL have port: digit_ready  output  1  block can accept a digit this cycle.
REQ-007 SHALL have port: op_key  input  1  operator-key pulse; advances entry.
REQ-008 SHALL have port: clr  input  1  synchronous clear.
REQ-009 SHALL have port: opnd_a  output  4*NDIG  operand A, most recent digit in bits [3:0].
REQ-010 SHALL have port: opnd_b  output  4*NDIG  operand B, same packing.
REQ-011 SHALL have port: opnd_valid  output  1  both operands complete and held.
REQ-012 SHALL have port: opnd_ack  input  1  consumer has taken the operands.
REQ-013 SHALL have port: sel  output  1  1 = digits route to A, 0 = route to B or holding.
REQ-014 SHALL have port: err  output  1  one-cycle pulse on a rejected digit.

Function
REQ-015 SHALL implement states ENT_A, ENT_B, HOLD; sel = (state == ENT_A).
REQ-016 SHALL accept a digit only when digit_valid && digit_ready, both high in the same cycle.
REQ-017 SHALL drive digit_ready = (ENT_A && cnt_a < NDIG) || (ENT_B && cnt_b < NDIG); digit_ready SHALL be 0 in HOLD.
REQ-018 SHALL, on an accepted digit, update the active register on the next edge: reg <= {reg[4*NDIG-5:0], digit}, and increment its count (one-cycle latency).
REQ-019 SHALL ignore digit_valid while the active register is full or the state is HOLD; no data SHALL change and err SHALL stay 0.
REQ-020 SHALL go ENT_A -> ENT_B on op_key, including with zero digits entered (operand = 0).
REQ-021 SHALL go ENT_B -> HOLD on op_key and set opnd_valid = 1 on the same edge.
REQ-022 SHALL ignore op_key in HOLD.
REQ-023 SHALL, when an accepted digit and op_key occur in the same cycle, store the digit into the current register and take the transition on the same edge.
REQ-024 SHALL hold opnd_a, opnd_b and opnd_valid stable in HOLD until opnd_ack.
REQ-025 SHALL, on opnd_ack in HOLD, go to ENT_A and zero opnd_a, opnd_b, both counts and opnd_valid on the next edge; opnd_ack outside HOLD SHALL be ignored.
REQ-026 SHALL give clr priority over all other inputs: any state -> ENT_A with all registers, counts and opnd_valid zeroed.

Reset
REQ-027 SHALL, while rst_n = 0, immediately force: state ENT_A, opnd_a = 0, opnd_b = 0, counts = 0, opnd_valid = 0, err = 0, sel = 1, digit_ready = 1.
REQ-028 SHALL discard a partially entered operand on reset asserted mid-entry; nothing SHALL be retained.

Configuration
REQ-029 SHALL, with DIGIT_DEMUX_BCD_CHECK_EN defined, reject an accepted handshake whose digit > 9: no register or count change, err = 1 for one cycle.
REQ-030 SHALL, without DIGIT_DEMUX_BCD_CHECK_EN, store every nibble 0..15 unchanged, with err tied to 0.

Structure
REQ-031 SHALL take the state enum type, the default NDIG and the BCD_MAX (9) constant from shared package calc_pkg.
REQ-032 SHALL instantiate the two operand registers as two copies of sub-module bcd_shift_reg (load enable, clear, NDIG-digit shift, count output).

Verification
REQ-033 SHALL cover: reset; digits 1,2,3 with sel = 1; op_key; digits 4,5; op_key -> opnd_a = 16'h0123, opnd_b = 16'h0045, opnd_valid = 1 with NDIG = 4.
REQ-034 SHALL cover: five digits 1..5 into A with NDIG = 4 -> digit_ready = 0 after the fourth digit, opnd_a = 16'h1234, fifth digit ignored.
REQ-035 SHALL cover: digit 7 and op_key in the same cycle in ENT_A -> opnd_a[3:0] = 7 and sel = 0 on the next edge.
REQ-036 SHALL cover: HOLD, then digit_valid and op_key -> no change; then opnd_ack -> next edge ENT_A, opnd_valid = 0, operands = 0.
REQ-037 SHALL cover: digit 4'hA with the macro defined -> err pulses 1 cycle, opnd_a unchanged; without the macro -> opnd_a[3:0] = 4'hA.
REQ-038 SHALL cover: rst_n low mid-entry after digits 8,9 -> outputs zero immediately, without waiting for a clock edge; clr in HOLD -> ENT_A next edge.
